// File: rtl/enemy_squad_mover.sv
// Squad of N horizontal enemies: patrol between edges, dodge with cooldown, timed death, then park.
// Optional descent on edge bounce is enabled by defining ENEMY_DESCEND_EN.
module enemy_squad_mover #(
  parameter int N_ENEMIES    = 4,
  parameter int INITIAL_X0   = 240,
  parameter int X_SPACING    = 60,
  parameter int INITIAL_Y    = 200,
  parameter int LEFT_EDGE    = 50,
  parameter int RIGHT_EDGE   = 500,
  parameter int X_SPEED      = 120,
  parameter int DODGE_FRAMES = 35,
  parameter int DEATH_FRAMES = 16,
  parameter int PARK_XY      = 781,
  parameter int DESCEND_STEP = 8,
  parameter int BOTTOM_Y     = 400
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic                     pause,
  input  logic [N_ENEMIES-1:0]     changeDirection,
  input  logic [N_ENEMIES-1:0]     dodgeBullet,
  input  logic [N_ENEMIES-1:0]     shotCollision,
  output logic [N_ENEMIES*11-1:0]  topLeftX,
  output logic [N_ENEMIES*11-1:0]  topLeftY,
  output logic [N_ENEMIES-1:0]     alive,
  output logic [N_ENEMIES-1:0]     exploding,
  output logic                     killPulse,
  output logic                     allDead,
  output logic                     reachedBottom
);

  typedef enum logic [1:0] {ST_ALIVE, ST_DODGE, ST_DYING, ST_DEAD} state_t;

  localparam logic [7:0]         DODGE_LOAD = 8'(DODGE_FRAMES - 1);
  localparam logic [7:0]         DEATH_LOAD = 8'(DEATH_FRAMES - 1);
  localparam logic signed [31:0] PARK_FX    = 32'(PARK_XY * 64);
  localparam logic signed [31:0] SPEED_FX   = 32'(X_SPEED);
  localparam logic signed [31:0] Y_INIT     = 32'(INITIAL_Y * 64);
`ifdef ENEMY_DESCEND_EN
  localparam logic signed [31:0] DESCEND_FX = 32'(DESCEND_STEP * 64);
  localparam logic signed [31:0] BOTTOM_FX  = 32'(BOTTOM_Y * 64);
`endif

  logic                 tick;
  logic [N_ENEMIES-1:0] hit_vec;
  logic [N_ENEMIES-1:0] dead_vec;
  logic [N_ENEMIES-1:0] bottom_vec;

  assign tick = startOfFrame & ~pause;

  for (genvar i = 0; i < N_ENEMIES; i++) begin : g_enemy
    localparam logic signed [31:0] X_INIT = 32'((INITIAL_X0 + i * X_SPACING) * 64);

    state_t             state, state_nxt;
    logic               dir_right, dir_nxt;
    logic [7:0]         cnt, cnt_nxt;
    logic signed [31:0] x, x_nxt, y, y_nxt;
    logic signed [31:0] x_pix, x_moved;
    logic               dir_req, dir_edge, hit;

    always_ff @(posedge clk) begin
      if (resetN) begin
        state     <= ST_ALIVE;
        dir_right <= 1'b1;
        cnt       <= '0;
        x         <= X_INIT;
        y         <= Y_INIT;
      end else begin
        state     <= state_nxt;
        dir_right <= dir_nxt;
        cnt       <= cnt_nxt;
        x         <= x_nxt;
        y         <= y_nxt;
      end
    end

    assign x_pix = x >>> 6;

    always_comb begin
      state_nxt = state;
      dir_nxt   = dir_right;
      cnt_nxt   = cnt;
      x_nxt     = x;
      y_nxt     = y;
      hit       = 1'b0;
      dir_req   = dir_right;
      dir_edge  = dir_right;
      x_moved   = x;
      case (state)
        ST_ALIVE, ST_DODGE: begin
          if (shotCollision[i]) begin
            state_nxt = ST_DYING;
            cnt_nxt   = DEATH_LOAD;
            hit       = 1'b1;
          end else begin
            if (state == ST_ALIVE && (changeDirection[i] || dodgeBullet[i])) begin
              dir_req   = ~dir_right;
              state_nxt = ST_DODGE;
              cnt_nxt   = DODGE_LOAD;
            end else if (state == ST_DODGE && tick) begin
              if (cnt == 8'd0) state_nxt = ST_ALIVE;
              else             cnt_nxt   = cnt - 8'd1;
            end
            dir_nxt = dir_req;
            if (tick) begin
              // Edge check wins over a dodge flip taken in the same cycle.
              dir_edge = dir_req;
              if (x_pix < LEFT_EDGE)       dir_edge = 1'b1;
              else if (x_pix > RIGHT_EDGE) dir_edge = 1'b0;
              x_moved = dir_edge ? (x + SPEED_FX) : (x - SPEED_FX);
              x_nxt   = (x_moved < 0) ? '0 : x_moved;
              dir_nxt = dir_edge;
`ifdef ENEMY_DESCEND_EN
              if (dir_edge != dir_req)
                y_nxt = (y + DESCEND_FX > BOTTOM_FX) ? BOTTOM_FX : (y + DESCEND_FX);
`endif
            end
          end
        end
        ST_DYING: begin
          if (tick) begin
            if (cnt == 8'd0) begin
              state_nxt = ST_DEAD;
              x_nxt     = PARK_FX;
              y_nxt     = PARK_FX;
            end else begin
              cnt_nxt = cnt - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end

    assign topLeftX[11*i +: 11] = x[16:6];
    assign topLeftY[11*i +: 11] = y[16:6];
    assign alive[i]     = (state == ST_ALIVE) || (state == ST_DODGE);
    assign exploding[i] = (state == ST_DYING);
    assign dead_vec[i]  = (state == ST_DEAD);
    assign hit_vec[i]   = hit;
`ifdef ENEMY_DESCEND_EN
    assign bottom_vec[i] = alive[i] && ((y >>> 6) >= BOTTOM_Y);
`else
    assign bottom_vec[i] = 1'b0;
`endif
  end

  // Several enemies hit together still give one pulse.
  always_ff @(posedge clk) begin
    if (resetN) killPulse <= 1'b0;
    else        killPulse <= |hit_vec;
  end

  assign allDead       = &dead_vec;
  assign reachedBottom = |bottom_vec;

endmodule

// File: doc/enemy_squad_mover.md
# enemy_squad_mover

Parametrised movement and lifecycle controller for a squad of `N_ENEMIES` independent horizontal enemies in the VGA game layer. Each enemy runs a bounded patrol between two edges in 1/64-pixel fixed point, reverses on tower or bullet dodge requests with a cooldown, and plays a timed death sequence before parking off-screen. Per-enemy positions feed the enemy bitmap/draw blocks. Status outputs (alive mask, kill pulse, all-dead) feed the game-control FSM.

## Interface

Parameters:
- `N_ENEMIES`, 4: number of enemy channels (1..8).
- `INITIAL_X0`, 240: enemy 0 start X in pixels.
- `X_SPACING`, 60: start X of enemy i is `INITIAL_X0 + i*X_SPACING`.
- `INITIAL_Y`, 200: start Y in pixels, all enemies.
- `LEFT_EDGE`, 50: left bounce limit in pixels.
- `RIGHT_EDGE`, 500: right bounce limit in pixels.
- `X_SPEED`, 120: step per frame in 1/64 pixel.
- `DODGE_FRAMES`, 35: frames during which further dodge requests are ignored.
- `DEATH_FRAMES`, 16: frames held in the explosion state.
- `PARK_XY`, 781: parked X and Y in pixels for dead enemies.
- `DESCEND_STEP`, 8: pixels dropped per edge bounce (macro only).
- `BOTTOM_Y`, 400: descent limit in pixels (macro only).

Ports:
- `clk` input 1: system clock.
- `resetN` input 1: reset. One clock; reset is synchronous and active-high. The port name is kept per codebase, and 1 means reset.
- `startOfFrame` input 1: one-cycle frame tick.
- `pause` input 1: freezes motion and timers.
- `changeDirection` input N: per-enemy tower-hit dodge request.
- `dodgeBullet` input N: per-enemy bullet dodge request.
- `shotCollision` input N: per-enemy hit.
- `topLeftX` output N*11: packed pixel X; enemy i occupies bits `[11i+10:11i]`.
- `topLeftY` output N*11: packed pixel Y, same packing as `topLeftX`.
- `alive` output N: enemy is in ALIVE or DODGE.
- `exploding` output N: enemy is in DYING.
- `killPulse` output 1: one cycle high when any enemy enters DYING.
- `allDead` output 1: every enemy is DEAD.
- `reachedBottom` output 1: some living enemy has Y ≥ `BOTTOM_Y`.

## Operation

Per-enemy state:
- State is one of ALIVE, DODGE, DYING or DEAD.
- Each enemy holds a direction bit (reset value +1, i.e. right).
- Each enemy holds a frame counter, 8 bits.
- Each enemy holds X/Y as signed 32-bit fixed point with 6 fractional bits.

Priority within a cycle: reset > collision > dodge request > frame update.

State transitions:
- ALIVE + `shotCollision[i]` → DYING. Counter loads `DEATH_FRAMES-1`; `killPulse` fires.
- ALIVE + (`changeDirection[i]` | `dodgeBullet[i]`) → DODGE. Direction flips once (both requests together still flip once); counter loads `DODGE_FRAMES-1`.
- DODGE + collision → DYING.
- DODGE ignores dodge requests.
- In DODGE, each unpaused `startOfFrame` decrements the counter. When it is 0 on a frame tick, the enemy returns to ALIVE.
- In DYING, position is frozen and collisions are ignored. Each unpaused frame tick decrements the counter. At 0 the enemy goes to DEAD and X and Y load `PARK_XY*64`.
- DEAD is terminal until reset; all inputs are ignored.

Frame update (ALIVE/DODGE, `startOfFrame` and not `pause`):
- If pixel X < `LEFT_EDGE`, direction becomes +1. If pixel X > `RIGHT_EDGE`, direction becomes -1. This edge check overrides a flip from the same cycle.
- X advances by ±`X_SPEED` using the resolved direction.
- X saturates at 0 and never goes negative.

`pause`:
- Suppresses all frame-tick effects, including motion and counters.
- Collisions and dodge flips are still processed.

Pixel outputs:
- Pixel value = fixed-point value >> 6, truncated to 11 bits.
- `alive`, `exploding`, `allDead` and `reachedBottom` are decoded from registered state.

## Timing

- All outputs are registered and update on the clock edge after the causing input.
- Position is valid the cycle after `startOfFrame`.
- Reset values:
  - X is `INITIAL_X0 + i*X_SPACING`; Y is `INITIAL_Y`.
  - State is ALIVE, so `alive` = all ones.
  - `exploding`, `killPulse`, `allDead` and `reachedBottom` are 0.
- Reset asserted mid-DYING or mid-DODGE restores the reset values on the next edge.
- Collision and `startOfFrame` in the same cycle: the enemy enters DYING and does not move.
- Multiple enemies hit in one cycle: a single `killPulse`.
- Reset is sampled only on `clk` edges.

## Configuration

- `ENEMY_DESCEND_EN` defined:
  - On every edge-triggered direction change of a living enemy, that enemy's Y increases by `DESCEND_STEP` pixels, saturating at `BOTTOM_Y`.
  - `reachedBottom` is computed as specified above.
- `ENEMY_DESCEND_EN` undefined:
  - Y is constant `INITIAL_Y` until death.
  - `reachedBottom` is tied 0.
  - No descent logic is synthesised.

## Test plan

- **Patrol:** Reset with N=4, then 20 frames with no events. Enemy 0 X goes 240→(240+20*120/64)=277 (truncated pixel). All `alive` = 4'b1111.
- **Edge bounce:** Force enemy 3 to start beyond `RIGHT_EDGE` (420+...), run frames. Direction becomes -1 on the first frame where X > 500, and X then decreases by 120/64 px per frame. With `ENEMY_DESCEND_EN`, Y goes 200→208 once.
- **Dodge cooldown:** Pulse `changeDirection[1]`, then pulse again 10 frames later. The direction flips only once, and a new request is honoured only after 35 frames.
- **Death sequence:** Assert `shotCollision[2]` together with `startOfFrame`. Next cycle `killPulse`=1 and `exploding[2]`=1, with X unchanged. After 16 frames X=Y=781, `alive[2]`=0 and `exploding[2]`=0.
- **All dead and reset:** Hit all 4 enemies in one cycle, giving a single `killPulse`. After 16 frames `allDead`=1. Assert `resetN`=1 for one cycle; positions and `alive` return to their reset values.
- **Pause:** Hold `pause` for 10 frames during DODGE. X and the counter stay frozen, and a collision during pause still enters DYING.
